imu_bram2uart_frame: RTL and testbench
======================================

// Module: imu_bram2uart_frame
// PURPOSE
//  Parametrised successor to the single-word IMU BRAM dump. On each imu_get_data rising edge it reads
//  N_WORDS words of DATA_W bits from BRAM (addresses 0..N_WORDS-1) and sends them as one framed packet
//  on an 8N1 UART line: header byte, payload bytes (MSB first), then XOR checksum.
//  It sits between the IMU sample BRAM and the board UART pin. Status outputs go to the PS/debug logic.
// PARAMETERS
//  ADDR_W   13         BRAM address width
//  DATA_W   16         BRAM word width; must be a multiple of 8 and <= 64
//  N_WORDS  6          words per frame; 1 <= N_WORDS <= 2**ADDR_W
//  CLK_FREQ 125000000  clk frequency in Hz
//  BAUD     115200     UART bit rate
//  HEADER   8'hA5      first byte of every frame
//  RD_LAT   1          BRAM read latency in cycles (1 or 2)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous reset, ACTIVE-LOW
//  imu_get_data in   1       frame trigger; level input, rising edge starts a frame
//  data_bram    in   DATA_W  BRAM read data, valid RD_LAT cycles after en_bram
//  addr_bram    out  ADDR_W  BRAM read address
//  en_bram      out  1       BRAM read enable, one-cycle pulse per word
//  tx_uart      out  1       UART TX line, idle high
//  busy         out  1       high from trigger acceptance until the checksum stop bit ends
//  frame_done   out  1       one-cycle pulse after the last stop bit
//  overrun      out  1       sticky; set when a trigger edge arrives while busy; cleared only by reset
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): tx_uart=1, addr_bram=0, en_bram=0, busy=0, frame_done=0, overrun=0,
//   FSM=IDLE, baud counter=0, checksum=0, edge-detect register=0. Reset mid-frame aborts at once:
//   tx_uart returns high on that edge even inside a byte. No resume.
//  Trigger: imu_get_data is registered once. An edge is prev==0 && cur==1. In IDLE, the edge moves to
//   HDR on the next cycle and busy rises together with that move. When busy, the edge is ignored and
//   overrun=1. A held-high level never starts a second frame.
//  FSM: IDLE -> HDR (send HEADER) -> FETCH (en_bram=1, addr_bram=word idx) -> WAIT (RD_LAT cycles;
//   capture data_bram into shift reg) -> BYTE (send DATA_W/8 bytes, MSB byte first) -> FETCH for the
//   next word, or CHK after word N_WORDS-1 -> CHK (send checksum) -> DONE (frame_done=1 for 1 cycle,
//   busy=0, addr_bram=0) -> IDLE.
//  addr_bram holds its value between fetches. The word index counts 0..N_WORDS-1 and has no wrap
//   inside a frame.
//  Checksum = XOR of all payload bytes (header excluded). It is cleared on HDR entry.
//  UART: CLKS_PER_BIT = CLK_FREQ/BAUD with integer truncation (1085 at defaults). Each byte is
//   1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each lasting exactly CLKS_PER_BIT cycles.
//   Bytes go back-to-back: the next start bit begins on the cycle after the previous stop bit ends,
//   except for the FETCH/WAIT gap of 1+RD_LAT cycles between words, where tx_uart stays 1.
//  Frame length = (2 + N_WORDS*DATA_W/8) bytes. Frame time = bytes*10*CLKS_PER_BIT + N_WORDS*(1+RD_LAT)
//   + 2 cycles from trigger edge to frame_done.
//  Simultaneous events: a trigger edge in the same cycle as frame_done is ignored and sets overrun.
//   A trigger in the first cycle of IDLE is accepted.
// STRUCTURE
//  Shared package imu_pkg: UART constants (START_BIT, STOP_BIT, BITS_PER_BYTE=8), default HEADER,
//   the FSM state enum, and the function clks_per_bit(CLK_FREQ,BAUD).
//  Sub-module uart_tx_byte (params CLK_FREQ, BAUD; ports clk, rst, start, data[7:0], tx, ready):
//   accepts start only when ready=1; tx=1 when idle. The frame FSM, word fetch and checksum stay in
//   the top level.
// TESTING
//  T1 defaults with N_WORDS=2; BRAM model returns 16'h1234+3*addr; trigger pulse -> tx decodes
//   A5 12 34 12 37 03; frame_done exactly once; en_bram pulsed twice at addr 0 then 1.
//  T2 bit timing: measure start-bit width -> 1085 cycles +/-0; total trigger-to-frame_done cycles
//   equal the formula above.
//  T3 second edge mid-frame -> frame unchanged, overrun=1 and stays 1 through a following clean frame.
//  T4 imu_get_data held high across two frame times -> exactly one frame, overrun=0.
//  T5 rst=0 for 1 cycle during payload byte 3 -> tx_uart=1, busy=0, addr_bram=0 next cycle;
//   a new trigger produces a full correct frame.
//  T6 DATA_W=32, RD_LAT=2, N_WORDS=1, data 32'hDEADBEEF -> A5 DE AD BE EF 22; frame_done one cycle.

Source files
------------

// File: rtl/imu_bram2uart_frame_pkg.sv
// Shared definitions for the IMU BRAM-to-UART framer: UART line constants,
// default frame header, frame FSM states and the baud divider helper.
package imu_pkg;

  localparam logic            START_BIT      = 1'b0;
  localparam logic            STOP_BIT       = 1'b1;
  localparam int unsigned     BITS_PER_BYTE  = 8;
  localparam logic [7:0]      DEFAULT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_WAIT,
    ST_BYTE,
    ST_CHK,
    ST_DONE
  } frame_state_t;

  // Clock cycles per UART bit, truncated.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/imu_bram2uart_frame_if.sv
// BRAM read port between the framer (master) and the sample memory (slave).
//   addr_bram : read address        (master -> slave)
//   en_bram   : one-cycle read pulse (master -> slave)
//   data_bram : read data, valid RD_LAT cycles after en_bram (slave -> master)
interface imu_bram2uart_frame_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
) ();

  logic [ADDR_W-1:0] addr_bram;
  logic              en_bram;
  logic [DATA_W-1:0] data_bram;

  modport master (output addr_bram, output en_bram, input data_bram);
  modport slave  (input addr_bram, input en_bram, output data_bram);

endinterface

// File: rtl/imu_bram2uart_frame_uart_tx_byte.sv
// 8N1 UART byte transmitter.
//   clk, rst(active-low, synchronous)
//   start/data : byte request, taken only while ready is high
//   tx         : serial line, idle high
//   ready      : idle, or in the final cycle of the stop bit so the next byte
//                can follow with no idle gap
module uart_tx_byte
  import imu_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 125000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W    = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned LAST_BIT = BITS_PER_BYTE + 1;

  logic             active;
  logic [3:0]       bit_idx;  // 0 start, 1..8 data, 9 stop
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_W'(CPB - 1));
  assign ready   = !active || (bit_end && (bit_idx == 4'(LAST_BIT)));

  // Bit sequencer; reset forces the line high immediately.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active  <= 1'b0;
      bit_idx <= '0;
      cnt     <= '0;
      shreg   <= '0;
      tx      <= STOP_BIT;
    end else if (start && ready) begin
      active  <= 1'b1;
      bit_idx <= '0;
      cnt     <= '0;
      shreg   <= data;
      tx      <= START_BIT;
    end else if (active) begin
      if (bit_end) begin
        cnt <= '0;
        if (bit_idx == 4'(LAST_BIT)) begin
          active <= 1'b0;
          tx     <= STOP_BIT;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= (bit_idx == 4'(BITS_PER_BYTE)) ? STOP_BIT : shreg[bit_idx[2:0]];
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/imu_bram2uart_frame.sv
// Reads N_WORDS BRAM words on each imu_get_data rising edge and sends them as
// one UART frame: HEADER, payload bytes MSB first, XOR checksum of the payload.
//   clk, rst(active-low, synchronous)
//   imu_get_data : frame trigger level
//   bram         : BRAM read port (master)
//   tx_uart      : UART line, idle high
//   busy         : frame in progress
//   frame_done   : one-cycle pulse after the checksum stop bit
//   overrun      : sticky, trigger edge seen while a frame was active
module imu_bram2uart_frame
  import imu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned N_WORDS  = 6,
  parameter int unsigned CLK_FREQ = 125000000,
  parameter int unsigned BAUD     = 115200,
  parameter logic [7:0]  HEADER   = DEFAULT_HEADER,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imu_get_data,
  imu_bram2uart_frame_if.master bram,
  output logic                 tx_uart,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned N_BYTES = DATA_W / BITS_PER_BYTE;
  localparam int unsigned BYTE_W  = $clog2(N_BYTES + 1);

  frame_state_t      state, state_d;
  logic              trig_cur, trig_prev, trig_edge;
  logic [ADDR_W-1:0] word_idx, word_idx_d;
  logic [BYTE_W-1:0] byte_idx, byte_idx_d;
  logic [1:0]        wait_cnt, wait_cnt_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [7:0]        chk, chk_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              en, en_d;
  logic              busy_d, frame_done_d, overrun_d;
  logic              uart_start_c, uart_ready;
  logic [7:0]        uart_data_c;

  assign trig_edge      = trig_cur && !trig_prev;
  assign bram.addr_bram = addr;
  assign bram.en_bram   = en;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      trig_cur   <= 1'b0;
      trig_prev  <= 1'b0;
      word_idx   <= '0;
      byte_idx   <= '0;
      wait_cnt   <= '0;
      shreg      <= '0;
      chk        <= '0;
      addr       <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      trig_cur   <= imu_get_data;
      trig_prev  <= trig_cur;
      word_idx   <= word_idx_d;
      byte_idx   <= byte_idx_d;
      wait_cnt   <= wait_cnt_d;
      shreg      <= shreg_d;
      chk        <= chk_d;
      addr       <= addr_d;
      en         <= en_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
    end
  end

  // Frame sequencing. Each next byte is requested in the cycle the UART
  // reports ready so bytes within a word and the checksum run back-to-back.
  always_comb begin
    state_d      = state;
    word_idx_d   = word_idx;
    byte_idx_d   = byte_idx;
    wait_cnt_d   = wait_cnt;
    shreg_d      = shreg;
    chk_d        = chk;
    addr_d       = addr;
    frame_done_d = 1'b0;
    uart_start_c = 1'b0;
    uart_data_c  = HEADER;
    overrun_d    = overrun || (trig_edge && (state != ST_IDLE));

    case (state)
      ST_IDLE: begin
        word_idx_d = '0;
        byte_idx_d = '0;
        if (trig_edge) begin
          state_d = ST_HDR;
          chk_d   = '0;
        end
      end
      ST_HDR: begin
        // byte_idx flags that the header has already been handed to the UART
        if (byte_idx == '0) begin
          uart_start_c = 1'b1;
          byte_idx_d   = BYTE_W'(1);
        end else if (uart_ready) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        // First byte goes straight from the read data to close the gap.
        if (wait_cnt == 2'(RD_LAT - 1)) begin
          uart_start_c = 1'b1;
          uart_data_c  = bram.data_bram[DATA_W-1 -: 8];
          chk_d        = chk ^ bram.data_bram[DATA_W-1 -: 8];
          shreg_d      = bram.data_bram << BITS_PER_BYTE;
          byte_idx_d   = BYTE_W'(1);
          state_d      = ST_BYTE;
        end else begin
          wait_cnt_d = wait_cnt + 2'd1;
        end
      end
      ST_BYTE: begin
        if (uart_ready) begin
          if (byte_idx != BYTE_W'(N_BYTES)) begin
            uart_start_c = 1'b1;
            uart_data_c  = shreg[DATA_W-1 -: 8];
            chk_d        = chk ^ shreg[DATA_W-1 -: 8];
            shreg_d      = shreg << BITS_PER_BYTE;
            byte_idx_d   = byte_idx + BYTE_W'(1);
          end else if (word_idx == ADDR_W'(N_WORDS - 1)) begin
            uart_start_c = 1'b1;
            uart_data_c  = chk;
            state_d      = ST_CHK;
          end else begin
            word_idx_d = word_idx + ADDR_W'(1);
            state_d    = ST_FETCH;
          end
        end
      end
      ST_CHK: begin
        if (uart_ready) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
          addr_d       = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    en_d = (state_d == ST_FETCH);
    if (state_d == ST_FETCH) begin
      addr_d = word_idx_d;
    end
    busy_d = (state_d == ST_HDR) || (state_d == ST_FETCH) || (state_d == ST_WAIT) ||
             (state_d == ST_BYTE) || (state_d == ST_CHK);
  end

  uart_tx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (uart_start_c),
    .data  (uart_data_c),
    .tx    (tx_uart),
    .ready (uart_ready)
  );

endmodule

// File: tb/tb_imu_bram2uart_frame.sv
// Bench for imu_bram2uart_frame: a fast-baud 16-bit/2-word instance for the
// frame behaviour, a 32-bit/RD_LAT=2 instance, and a default-parameter
// instance for the 1085-cycle bit width. Received bytes are decoded from the
// line and compared with frames built from the BRAM contents.
module tb_imu_bram2uart_frame;

  localparam int CLK_F  = 125000000;
  localparam int BAUD_F = 11520000;            // 10.85 clocks per bit, truncates to 10
  localparam int CPB    = CLK_F / BAUD_F;
  localparam int FT_M   = 6 * 10 * CPB + 2 * (1 + 1) + 2;
  localparam int FT_6   = 6 * 10 * CPB + 1 * (1 + 2) + 2;
  localparam int RST_AT = 2 + 30 * CPB + 2 + 2 + 4 * CPB;  // inside payload byte 3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, rst_aux = 1'b0, rst3 = 1'b0;
  logic trig_m = 1'b0, trig6 = 1'b0, trig3 = 1'b0;
  logic tx_m, busy_m, frame_done_m, overrun_m;
  logic tx6, busy6, frame_done6, overrun6;
  logic tx3, busy3, frame_done3, overrun3;

  imu_bram2uart_frame_if #(.ADDR_W(13), .DATA_W(16)) bram_m ();
  imu_bram2uart_frame_if #(.ADDR_W(13), .DATA_W(32)) bram6 ();
  imu_bram2uart_frame_if #(.ADDR_W(13), .DATA_W(16)) bram3 ();

  imu_bram2uart_frame #(
    .ADDR_W(13), .DATA_W(16), .N_WORDS(2), .CLK_FREQ(CLK_F), .BAUD(BAUD_F),
    .HEADER(8'hA5), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .imu_get_data(trig_m), .bram(bram_m),
    .tx_uart(tx_m), .busy(busy_m), .frame_done(frame_done_m), .overrun(overrun_m)
  );

  imu_bram2uart_frame #(
    .ADDR_W(13), .DATA_W(32), .N_WORDS(1), .CLK_FREQ(CLK_F), .BAUD(BAUD_F),
    .HEADER(8'hA5), .RD_LAT(2)
  ) dut6 (
    .clk(clk), .rst(rst_aux), .imu_get_data(trig6), .bram(bram6),
    .tx_uart(tx6), .busy(busy6), .frame_done(frame_done6), .overrun(overrun6)
  );

  imu_bram2uart_frame dut3 (
    .clk(clk), .rst(rst3), .imu_get_data(trig3), .bram(bram3),
    .tx_uart(tx3), .busy(busy3), .frame_done(frame_done3), .overrun(overrun3)
  );

  // BRAM models: valid data exactly RD_LAT cycles after en, noise otherwise.
  logic [15:0] mem16 [2];
  always @(posedge clk) begin
    if (bram_m.en_bram)
      bram_m.data_bram <= (bram_m.addr_bram < 13'd2) ? mem16[bram_m.addr_bram[0]] : 16'hBAD0;
    else
      bram_m.data_bram <= 16'($urandom);
  end

  logic        en6_d;
  logic [12:0] addr6_d;
  always @(posedge clk) begin
    en6_d   <= bram6.en_bram;
    addr6_d <= bram6.addr_bram;
    if (en6_d)
      bram6.data_bram <= (addr6_d == 13'd0) ? 32'hDEADBEEF : 32'h0BAD0BAD;
    else
      bram6.data_bram <= $urandom;
  end

  assign bram3.data_bram = '0;

  // Line monitors.
  logic [12:0] en_log [$];
  int fd_m = 0, fd_6 = 0;
  always @(negedge clk) begin
    if (bram_m.en_bram) en_log.push_back(bram_m.addr_bram);
    if (frame_done_m) fd_m <= fd_m + 1;
    if (frame_done6) fd_6 <= fd_6 + 1;
  end

  // 8N1 receiver on the combined fast-baud lines, sampling mid-bit.
  logic       rx_line;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  assign rx_line = tx_m & tx6;

  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (rx_line == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = rx_line;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: header, each word MSB byte first, XOR of payload bytes.
  task automatic build_exp16();
    logic [7:0] c, byt;
    c = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int w = 0; w < 2; w++)
      for (int k = 1; k >= 0; k--) begin
        byt = 8'((mem16[w] >> (8 * k)) & 16'hFF);
        exp_q.push_back(byt);
        c = c ^ byt;
      end
    exp_q.push_back(c);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 2; i++) mem16[i] = 16'($urandom);
    build_exp16();
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i),
            (i < rx_q.size()) ? 64'(rx_q[i]) : 64'hFFFF, 64'(exp_q[i]));
    rx_q.delete();
  endtask

  task automatic set_trig(input int sel, input logic v);
    if (sel == 0) trig_m = v;
    else trig6 = v;
  endtask

  // Raise the trigger (sampled at edge P), count cycles from P to frame_done.
  // Trigger drops after `width` cycles; optional one-cycle re-pulse at glitch_at.
  task automatic trig_wait(input int sel, input int width, input int glitch_at, output int cyc);
    @(negedge clk);
    set_trig(sel, 1'b1);
    @(posedge clk);
    cyc = 0;
    #1;
    while (cyc < 5000) begin
      if (cyc + 1 >= width) set_trig(sel, 1'b0);
      if (glitch_at >= 0 && cyc == glitch_at) set_trig(sel, 1'b1);
      @(posedge clk);
      cyc++;
      #1;
      if (((sel == 0) ? frame_done_m : frame_done6) == 1'b1) break;
    end
  endtask

  initial begin
    int cyc, f0, w, to;
    logic seen_busy;

    repeat (3) @(negedge clk);
    rst = 1'b1; rst_aux = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;

    check("rst_tx", tx_m, 1'b1);
    check("rst_busy", busy_m, 1'b0);
    check("rst_done", frame_done_m, 1'b0);
    check("rst_overrun", overrun_m, 1'b0);
    check("rst_en", bram_m.en_bram, 1'b0);
    check("rst_addr", bram_m.addr_bram, 13'd0);

    // Fixed contents, fixed expected bytes, fetch order and frame time.
    mem16[0] = 16'h1234; mem16[1] = 16'h1237;
    exp_q = '{8'hA5, 8'h12, 8'h34, 8'h12, 8'h37, 8'h03};
    en_log.delete(); rx_q.delete(); f0 = fd_m;
    trig_wait(0, 1, -1, cyc);
    check("t1_frame_cycles", cyc, FT_M);
    cmp_frame("t1");
    repeat (3) @(negedge clk);
    check("t1_done_count", fd_m - f0, 1);
    check("t1_en_count", en_log.size(), 2);
    if (en_log.size() == 2) begin
      check("t1_en_addr0", en_log[0], 13'd0);
      check("t1_en_addr1", en_log[1], 13'd1);
    end
    check("t1_busy_after", busy_m, 1'b0);
    check("t1_addr_after", bram_m.addr_bram, 13'd0);

    // Start-bit width at default clock and baud.
    @(negedge clk); trig3 = 1'b1;
    to = 0; w = 0;
    while (tx3 !== 1'b0 && to < 100) begin @(negedge clk); to++; end
    while (tx3 === 1'b0 && w < 5000) begin @(negedge clk); w++; end
    check("t2_start_width", w, 1085);
    rst3 = 1'b0; trig3 = 1'b0;

    // Level held across two frame times: one frame, no overrun.
    rand_mem(); f0 = fd_m;
    trig_wait(0, 100000, -1, cyc);
    check("t4_frame_cycles", cyc, FT_M);
    repeat (FT_M + 100) @(negedge clk);
    check("t4_done_count", fd_m - f0, 1);
    check("t4_overrun", overrun_m, 1'b0);
    cmp_frame("t4");
    trig_m = 1'b0;
    repeat (5) @(negedge clk);

    // Trigger edge landing in the first IDLE cycle is accepted.
    rand_mem();
    trig_wait(0, 1, -1, cyc);
    cmp_frame("t7a");
    rand_mem();
    trig_wait(0, 1, -1, cyc);
    check("t7_frame_cycles", cyc, FT_M);
    check("t7_overrun", overrun_m, 1'b0);
    cmp_frame("t7b");

    // Random contents, pulse widths and idle gaps.
    for (int n = 0; n < 4; n++) begin
      rand_mem();
      repeat ($urandom_range(30, 0)) @(negedge clk);
      trig_wait(0, int'($urandom_range(5, 1)), -1, cyc);
      check($sformatf("rnd%0d_cycles", n), cyc, FT_M);
      cmp_frame($sformatf("rnd%0d", n));
      check($sformatf("rnd%0d_overrun", n), overrun_m, 1'b0);
      @(negedge clk);
    end

    // Second edge mid-frame: frame intact, overrun sticky.
    rand_mem();
    trig_wait(0, 1, 200, cyc);
    check("t3_frame_cycles", cyc, FT_M);
    cmp_frame("t3");
    check("t3_overrun", overrun_m, 1'b1);
    repeat (10) @(negedge clk);
    rand_mem();
    trig_wait(0, 1, -1, cyc);
    cmp_frame("t3_clean");
    check("t3_overrun_sticky", overrun_m, 1'b1);

    // One-cycle reset inside payload byte 3, then a full frame.
    repeat (10) @(negedge clk);
    rand_mem();
    @(negedge clk); trig_m = 1'b1;
    @(posedge clk); #1 trig_m = 1'b0;
    repeat (RST_AT - 1) @(posedge clk);
    #1 check("t5_busy_before", busy_m, 1'b1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("t5_tx", tx_m, 1'b1);
    check("t5_busy", busy_m, 1'b0);
    check("t5_addr", bram_m.addr_bram, 13'd0);
    check("t5_overrun", overrun_m, 1'b0);
    @(negedge clk); rst = 1'b1;
    repeat (15 * CPB) @(negedge clk);
    rx_q.delete();
    rand_mem(); f0 = fd_m;
    trig_wait(0, 1, -1, cyc);
    check("t5_frame_cycles", cyc, FT_M);
    cmp_frame("t5");
    repeat (3) @(negedge clk);
    check("t5_done_count", fd_m - f0, 1);

    // Trigger edge coinciding with frame_done: ignored, sets overrun.
    rand_mem();
    @(negedge clk); trig_m = 1'b1;
    @(posedge clk); #1 trig_m = 1'b0;
    repeat (FT_M - 1) @(posedge clk);
    @(negedge clk); trig_m = 1'b1;
    @(posedge clk); #1;
    check("t5b_done_now", frame_done_m, 1'b1);
    @(negedge clk); trig_m = 1'b0;
    @(posedge clk); #1;
    check("t5b_overrun", overrun_m, 1'b1);
    cmp_frame("t5b");
    seen_busy = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy_m) seen_busy = 1'b1;
    end
    check("t5b_no_restart", seen_busy, 1'b0);

    // 32-bit word, RD_LAT=2, single word.
    exp_q = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    rx_q.delete(); f0 = fd_6;
    trig_wait(1, 1, -1, cyc);
    check("t6_frame_cycles", cyc, FT_6);
    repeat (3) @(negedge clk);
    check("t6_done_count", fd_6 - f0, 1);
    check("t6_busy_after", busy6, 1'b0);
    cmp_frame("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
